// File: rtl/mprj_cfg_loader_if.sv
// Handshake, configuration-store and serial-chain signals of the pad configuration loader.
interface mprj_cfg_loader_if #(
    parameter int CFG_BITS = 13
);
    logic                start;
    logic                busy;
    logic                done;
    logic [5:0]          cfg_addr;
    logic [CFG_BITS-1:0] cfg_data;
    logic                serial_resetn;
    logic                serial_clock;
    logic                serial_data_out;
    logic                serial_load;

    modport master (
        input  start, cfg_data,
        output busy, done, cfg_addr, serial_resetn, serial_clock, serial_data_out, serial_load
    );

    modport slave (
        output start, cfg_data,
        input  busy, done, cfg_addr, serial_resetn, serial_clock, serial_data_out, serial_load
    );
endinterface

// File: rtl/mprj_cfg_loader.sv
// Walks the pad configuration store from the top pad down and shifts each word MSB first
// into the user-project serial chain, then strobes serial_load to latch the whole chain.
module mprj_cfg_loader #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 4
) (
    input logic               clock,
    input logic               reset,
    mprj_cfg_loader_if.master bus
);
    localparam int PAD_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
    localparam int BIT_W = $clog2(CFG_BITS);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, RST_CHAIN, FETCH, SHIFT, LOAD, DONE} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [PAD_W-1:0]    pad_q, pad_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [CFG_BITS-1:0] sr_q, sr_d;
    // FETCH: second (capture) cycle; SHIFT: current serial_clock level
    logic                phase_q, phase_d;
    logic                div_last;

    logic       busy, done, serial_resetn, serial_clock, serial_data_out, serial_load;
    logic [5:0] cfg_addr;

    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_d         = state_q;
        div_d           = div_q;
        pad_d           = pad_q;
        bit_d           = bit_q;
        sr_d            = sr_q;
        phase_d         = phase_q;
        busy            = 1'b1;
        done            = 1'b0;
        cfg_addr        = '0;
        serial_resetn   = 1'b1;
        serial_clock    = 1'b0;
        serial_data_out = 1'b0;
        serial_load     = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) begin
                    state_d = RST_CHAIN;
                    div_d   = '0;
                end
            end
            RST_CHAIN: begin
                serial_resetn = 1'b0;
                if (div_last) begin
                    state_d = FETCH;
                    div_d   = '0;
                    pad_d   = PAD_W'(NUM_PADS - 1);
                    phase_d = 1'b0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            FETCH: begin
                cfg_addr = 6'(pad_q);
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    sr_d    = bus.cfg_data;
                    bit_d   = '0;
                    div_d   = '0;
                    phase_d = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                serial_clock    = phase_q;
                serial_data_out = sr_q[CFG_BITS-1];
                if (div_last) begin
                    div_d   = '0;
                    phase_d = ~phase_q;
                    // Data moves only with the falling edge, giving a full phase of setup and hold.
                    if (phase_q) begin
                        sr_d  = {sr_q[CFG_BITS-2:0], 1'b0};
                        bit_d = bit_q + 1'b1;
                        if (bit_q == BIT_W'(CFG_BITS - 1)) begin
                            if (pad_q != '0) begin
                                pad_d   = pad_q - 1'b1;
                                state_d = FETCH;
                            end else begin
                                state_d = LOAD;
                            end
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LOAD: begin
                serial_load = 1'b1;
                if (div_last) begin
                    div_d   = '0;
                    state_d = DONE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            pad_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pad_q   <= pad_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            phase_q <= phase_d;
        end
    end

    assign bus.busy            = busy;
    assign bus.done            = done;
    assign bus.cfg_addr        = cfg_addr;
    assign bus.serial_resetn   = serial_resetn;
    assign bus.serial_clock    = serial_clock;
    assign bus.serial_data_out = serial_data_out;
    assign bus.serial_load     = serial_load;
endmodule

// File: tb/tb_mprj_cfg_loader.sv
// Three loader configurations checked every cycle against an offset-based timeline model,
// plus literal checks of bit order, edge counts and sequence lengths.
module tb_mprj_cfg_loader;
    typedef struct {
        bit busy, done, rstn, sclk, load, fetch;
        int addr, pad, bitn;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [2:0]  rst_v, start_v, done_v;
    logic [11:0] outv [3];
    int          k_v [3];
    int          rises_v [3], zeros_v [3], busy_v [3], rstlo_v [3], load_v [3], donec_v [3], seq_v [3];
    logic [63:0] bits_v [3];
    int          checks = 0;
    int          errors = 0;

    // Expected outputs k cycles after start was accepted (k<0 means idle).
    function automatic exp_t model(input int p, input int b, input int d, input int k);
        exp_t e;
        int   len, j, r, s, pad;
        len = 2 + 2 * d * b;
        e.busy = 0; e.done = 0; e.rstn = 1; e.sclk = 0; e.load = 0; e.fetch = 0;
        e.addr = 0; e.pad = -1; e.bitn = 0;
        if (k >= 0 && k < d) begin
            e.busy = 1; e.rstn = 0;
        end else if (k >= d && k < d + p * len) begin
            e.busy = 1;
            j   = k - d;
            r   = j % len;
            pad = p - 1 - j / len;
            if (r < 2) begin
                e.fetch = (r == 0);
                e.addr  = pad;
            end else begin
                s      = r - 2;
                e.sclk = (s % (2 * d)) >= d;
                e.pad  = pad;
                e.bitn = b - 1 - s / (2 * d);
            end
        end else if (k >= d + p * len && k < 2 * d + p * len) begin
            e.busy = 1; e.load = 1;
        end else if (k == 2 * d + p * len) begin
            e.done = 1;
        end
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int NP = (g == 0) ? 2 : (g == 1) ? 38 : 3;
        localparam int NB = (g == 0) ? 4 : (g == 1) ? 13 : 5;
        localparam int ND = (g == 0) ? 1 : (g == 1) ? 4 : 3;
        localparam int T  = 2 * ND + NP * (2 + 2 * ND * NB);

        logic          rst, start;
        logic [NB-1:0] store [NP];
        logic [NB-1:0] rdata;
        int            k = -1;
        logic          sclk_prev = 1'b0;
        logic          busy_prev = 1'b0;

        mprj_cfg_loader_if #(.CFG_BITS(NB)) bus ();
        mprj_cfg_loader #(.NUM_PADS(NP), .CFG_BITS(NB), .CLK_DIV(ND)) dut (
            .clock(clock), .reset(rst), .bus(bus)
        );

        assign rst           = rst_v[g];
        assign start         = start_v[g];
        assign bus.start     = start;
        assign bus.cfg_data  = rdata;
        assign done_v[g]     = bus.done;
        assign k_v[g]        = k;
        assign outv[g]       = {bus.busy, bus.done, bus.serial_resetn, bus.serial_clock,
                                bus.serial_data_out, bus.serial_load, bus.cfg_addr};

        // Store answers one cycle after the address is presented.
        always @(posedge clock)
            rdata <= (int'(bus.cfg_addr) < NP) ? store[int'(bus.cfg_addr)] : '0;

        always @(posedge clock or posedge rst) begin
            if (rst)           k <= -1;
            else if (k == T)   k <= -1;
            else if (k >= 0)   k <= k + 1;
            else if (start)    k <= 0;
        end

        always @(negedge clock) begin
            exp_t        e;
            logic        esdo;
            logic [11:0] ev, av;
            e    = model(NP, NB, ND, k);
            esdo = (e.pad >= 0) ? store[e.pad][e.bitn] : 1'b0;
            ev   = {e.busy, e.done, e.rstn, e.sclk, esdo, e.load, e.fetch ? 6'(e.addr) : 6'd0};
            av   = {outv[g][11:6], e.fetch ? outv[g][5:0] : 6'd0};
            checks++;
            if (av !== ev) begin
                errors++;
                $display("FAIL cfg%0d outputs k=%0d: got %b expected %b", g, k, av, ev);
            end
            if (bus.serial_clock && !sclk_prev) begin
                rises_v[g]++;
                bits_v[g] = {bits_v[g][62:0], bus.serial_data_out};
                if (!bus.serial_data_out) zeros_v[g]++;
            end
            if (bus.busy) busy_v[g]++;
            if (bus.busy && !busy_prev) seq_v[g]++;
            if (!bus.serial_resetn) rstlo_v[g]++;
            if (bus.serial_load) load_v[g]++;
            if (bus.done) donec_v[g]++;
            sclk_prev = bus.serial_clock;
            busy_prev = bus.busy;
        end
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic clr(input int i);
        rises_v[i] = 0; zeros_v[i] = 0; busy_v[i] = 0; rstlo_v[i] = 0;
        load_v[i] = 0; donec_v[i] = 0; seq_v[i] = 0; bits_v[i] = '0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic pulse(input int i);
        start_v[i] = 1'b1;
        cyc(1);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, input string nm);
        int c = 0;
        while (done_v[i] !== 1'b1 && c < budget) begin
            @(negedge clock);
            c++;
        end
        chk({nm, " done seen"}, longint'(done_v[i] === 1'b1), 1);
        cyc(1);
    endtask

    initial begin
        exp_t       e;
        logic [7:0] pat;
        logic [3:0] ps [2];
        bit         prev;
        int         c;
        rst_v   = '1;
        start_v = '0;
        for (int i = 0; i < 3; i++) clr(i);

        // Pin the model against hand-derived timeline points.
        e = model(2, 4, 1, 21);   chk("model cfg0 k21 load", e.load, 1);
        e = model(2, 4, 1, 22);   chk("model cfg0 k22 done", e.done, 1);
        chk("model cfg0 k22 busy", e.busy, 0);
        e = model(2, 4, 1, 4);    chk("model cfg0 k4 sclk", e.sclk, 1);
        chk("model cfg0 k4 pad", e.pad, 1);
        chk("model cfg0 k4 bit", e.bitn, 3);
        e = model(38, 13, 4, 4035); chk("model dflt k4035 load", e.load, 1);
        e = model(38, 13, 4, 4036); chk("model dflt k4036 done", e.done, 1);
        ps[1] = 4'hA; ps[0] = 4'h5; pat = '0; prev = 1'b0;
        for (int kk = 0; kk <= 22; kk++) begin
            e = model(2, 4, 1, kk);
            if (e.sclk && !prev) pat = {pat[6:0], ps[e.pad][e.bitn]};
            prev = e.sclk;
        end
        chk("model cfg0 bit pattern", pat, 8'hA5);

        cfg[0].store[1] = 4'hA;
        cfg[0].store[0] = 4'h5;
        for (int i = 0; i < 38; i++) cfg[1].store[i] = 13'h1FFF;
        for (int i = 0; i < 3; i++) cfg[2].store[i] = 5'($urandom);

        cyc(3);
        for (int i = 0; i < 3; i++) chk($sformatf("cfg%0d reset outputs", i), outv[i], 12'h200);
        rst_v = '0;
        cyc(3);

        // Small chain: bit order, edge count, busy length.
        clr(0); pulse(0); wait_done(0, 60, "cfg0 seq");
        chk("cfg0 serial bits", bits_v[0][7:0], 8'hA5);
        chk("cfg0 rises", rises_v[0], 8);
        chk("cfg0 busy cycles", busy_v[0], 22);
        chk("cfg0 resetn low cycles", rstlo_v[0], 1);
        chk("cfg0 load cycles", load_v[0], 1);
        chk("cfg0 done pulses", donec_v[0], 1);

        // Default parameters, all-ones store.
        clr(1); pulse(1); wait_done(1, 4100, "dflt seq");
        chk("dflt rises", rises_v[1], 494);
        chk("dflt zero bits", zeros_v[1], 0);
        chk("dflt busy cycles", busy_v[1], 4036);
        chk("dflt load cycles", load_v[1], 4);

        // start held high: three back-to-back sequences of 24 cycles each.
        clr(0); start_v[0] = 1'b1; cyc(60); start_v[0] = 1'b0;
        wait_done(0, 60, "cfg0 held");
        chk("cfg0 held sequences", seq_v[0], 3);
        chk("cfg0 held done pulses", donec_v[0], 3);

        // start toggling while busy must not queue another sequence.
        clr(0); pulse(0);
        for (int i = 0; i < 15; i++) begin start_v[0] = 1'($urandom_range(0, 1)); cyc(1); end
        start_v[0] = 1'b0;
        wait_done(0, 60, "cfg0 busy pulses"); cyc(4);
        chk("cfg0 busy-pulse sequences", seq_v[0], 1);
        chk("cfg0 busy-pulse done pulses", donec_v[0], 1);

        // CLK_DIV=3 chain with random words and random start noise.
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 3; i++) cfg[2].store[i] = 5'($urandom);
            clr(2); cyc($urandom_range(0, 5)); pulse(2);
            for (int i = 0; i < 10; i++) begin start_v[2] = 1'($urandom); cyc(1); end
            start_v[2] = 1'b0;
            wait_done(2, 200, "cfg2 seq");
            chk("cfg2 rises", rises_v[2], 15);
            chk("cfg2 busy cycles", busy_v[2], 102);
        end

        // Abort in the low phase of the third bit of the first pad (k = 3+2+12+1).
        clr(2); pulse(2); c = 0;
        while (k_v[2] != 18 && c < 200) begin @(negedge clock); c++; end
        chk("cfg2 reached third bit", k_v[2], 18);
        chk("cfg2 rises before abort", rises_v[2], 2);
        #2 rst_v[2] = 1'b1;
        #1 chk("cfg2 async reset outputs", outv[2], 12'h200);
        cyc(2); rst_v[2] = 1'b0; cyc(6);
        chk("cfg2 no load after abort", load_v[2], 0);
        chk("cfg2 idle after abort", seq_v[2], 1);
        clr(2); pulse(2); wait_done(2, 200, "cfg2 after abort");
        chk("cfg2 rises after abort", rises_v[2], 15);
        chk("cfg2 load after abort", load_v[2], 3);
        chk("cfg2 busy after abort", busy_v[2], 102);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mprj_cfg_loader.md
MPRJ_CFG_LOADER -- requirements
Module: mprj_cfg_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all sequential state SHALL be clocked on the rising edge of clock.
REQ-002 Parameter NUM_PADS, default 38: number of user-project pads in the serial configuration chain, legal range 1..64.
REQ-003 Parameter CFG_BITS, default 13: configuration bits per pad, legal range 2..16.
REQ-004 Parameter CLK_DIV, default 4: clock cycles per serial_clock phase (low or high), legal range >=1.
REQ-005 Ports SHALL be:
- clock  input  1  system clock.
- reset  input  1  asynchronous active-high reset.
- start  input  1  level; sampled only in IDLE.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle completion pulse.
- cfg_addr  output  6  pad index presented to the configuration store.
- cfg_data  input  CFG_BITS  word for cfg_addr, valid one cycle after cfg_addr is driven.
- serial_resetn  output  1  active-low chain clear.
- serial_clock  output  1  chain shift clock.
- serial_data_out  output  1  chain data, MSB first.
- serial_load  output  1  chain latch strobe, active high.

Function
REQ-006 The FSM states SHALL be IDLE, RST_CHAIN, FETCH, SHIFT, LOAD and DONE.
REQ-007 In IDLE, start=1 SHALL move the FSM to RST_CHAIN on the next edge; start while busy=1 SHALL be ignored.
REQ-008 RST_CHAIN SHALL drive serial_resetn=0 for exactly CLK_DIV cycles, then enter FETCH with pad index = NUM_PADS-1.
REQ-009 FETCH SHALL last 2 cycles.
- Cycle 1: drive cfg_addr = pad index.
- Cycle 2: capture cfg_data into the shift register, clear the bit counter, then enter SHIFT.
REQ-010 SHIFT, per bit:
- serial_data_out = shift register MSB.
- serial_clock low for CLK_DIV cycles, then high for CLK_DIV cycles.
- On the high-to-low return, shift left by one and increment the bit counter.
REQ-011 serial_data_out SHALL change only while serial_clock is low; setup and hold to each serial_clock rise SHALL be >=CLK_DIV cycles.
REQ-012 After CFG_BITS bits the FSM SHALL leave SHIFT.
- Pad index >0: decrement the pad index and go to FETCH.
- Pad index =0: go to LOAD.
REQ-013 LOAD SHALL hold serial_load=1 for exactly CLK_DIV cycles with serial_clock=0, then enter DONE.
REQ-014 DONE SHALL assert done=1 for one cycle with busy=0, then return to IDLE; start held high SHALL begin a new sequence from that IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE and DONE.
REQ-016 Busy duration SHALL be exactly CLK_DIV + NUM_PADS*(2 + 2*CLK_DIV*CFG_BITS) + CLK_DIV cycles; default value 4036.
REQ-017 Exactly NUM_PADS*CFG_BITS serial_clock rising edges SHALL occur per sequence.
REQ-018 Outside RST_CHAIN, serial_resetn SHALL be 1; outside SHIFT, serial_clock and serial_data_out SHALL be 0.
REQ-019 Pad-index and bit counters SHALL be sized to hold NUM_PADS-1 and CFG_BITS-1 without wrap; cfg_addr SHALL be zero-extended to 6 bits.

Reset
REQ-020 reset=1 SHALL immediately and asynchronously force the following values, including mid-sequence:
- FSM=IDLE, busy=0, done=0, cfg_addr=0.
- serial_clock=0, serial_data_out=0, serial_load=0, serial_resetn=1.
REQ-021 After reset deassertion, the block SHALL take no action until start is sampled high in IDLE; a partially shifted chain SHALL never be followed by serial_load.

Verification
REQ-022 Test bench configuration NUM_PADS=2, CFG_BITS=4, CLK_DIV=1, store {pad1=4'hA, pad0=4'h5}; pulse start -> serial_resetn low for 1 cycle, then:
- serial_data_out sampled at serial_clock rises = 1,0,1,0,0,1,0,1.
- serial_load high for 1 cycle.
- busy high for 22 cycles, then done for 1 cycle.
REQ-023 Default parameters, all store words 13'h1FFF -> 494 serial_clock rises, all with serial_data_out=1; busy high for 4036 cycles.
REQ-024 start held high continuously -> back-to-back sequences; exactly one done per sequence; start pulses during busy produce no extra sequence.
REQ-025 reset asserted during the third SHIFT bit -> all outputs at reset values in the same cycle with no serial_load pulse; a subsequent start yields a full, correct sequence.
REQ-026 CLK_DIV=3 -> serial_clock low 3 cycles and high 3 cycles; serial_data_out is stable from 3 cycles before each rise to 3 cycles after it.
